fb_swap_scanout: RTL and testbench

//  Display-side responder to the rasterizer's framebuffer swap handshake (swap_fb/fb_addr/fb_size/

---
 rtl/fb_swap_scanout.sv | 260 ++++++++++++++++++++++++++
 tb/tb_fb_swap_scanout.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_swap_scanout.sv
// fb_swap_scanout: commits framebuffer swaps from the rasterizer and scans the front buffer
// out once per frame over an AXI4 read master into an AXI-Stream pixel output.
module fb_swap_scanout #(
    parameter int unsigned ADDR_WIDTH          = 32,
    parameter int unsigned ID_WIDTH            = 8,
    parameter int unsigned DATA_WIDTH          = 32,
    parameter int unsigned FB_SIZE_IN_PIXEL_LG = 20,
    parameter int unsigned BURST_LEN           = 16,
    parameter int unsigned FIFO_DEPTH_LG       = 6
) (
    input  logic                           aclk,
    input  logic                           resetn,
    input  logic                           swap_fb,
    input  logic                           swap_fb_enable_vsync,
    input  logic [ADDR_WIDTH-1:0]          fb_addr,
    input  logic [FB_SIZE_IN_PIXEL_LG-1:0] fb_size,
    output logic                           fb_swapped,
    input  logic                           vsync,
    output logic                           scan_overrun,
    output logic [ID_WIDTH-1:0]            m_axi_arid,
    output logic [ADDR_WIDTH-1:0]          m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic                           m_axi_arlock,
    output logic [3:0]                     m_axi_arcache,
    output logic [2:0]                     m_axi_arprot,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [ID_WIDTH-1:0]            m_axi_rid,
    input  logic [DATA_WIDTH-1:0]          m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rlast,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready,
    output logic                           m_pixel_axis_tvalid,
    input  logic                           m_pixel_axis_tready,
    output logic                           m_pixel_axis_tlast,
    output logic [DATA_WIDTH-1:0]          m_pixel_axis_tdata
);

    localparam int unsigned AW         = ADDR_WIDTH;
    localparam int unsigned SW         = FB_SIZE_IN_PIXEL_LG;
    localparam int unsigned BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int unsigned PIX_SHIFT  = $clog2(DATA_WIDTH / 16);
    localparam int unsigned DEPTH      = 1 << FIFO_DEPTH_LG;
    localparam int unsigned CNTW       = FIFO_DEPTH_LG + 1;
    localparam int unsigned CW         = FIFO_DEPTH_LG + 2;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_DRAIN = 2'd2} state_e;

    state_e                   state_q, state_d;
    logic                     pend_valid_q, pend_valid_d;
    logic [AW-1:0]            pend_addr_q, pend_addr_d;
    logic [SW-1:0]            pend_size_q, pend_size_d;
    logic                     front_valid_q, front_valid_d;
    logic [AW-1:0]            front_addr_q, front_addr_d;
    logic [SW-1:0]            front_size_q, front_size_d;
    logic                     fb_swapped_q, fb_swapped_d;
    logic                     overrun_q, overrun_d;
    logic                     arvalid_q, arvalid_d;
    logic [AW-1:0]            araddr_q, araddr_d;
    logic [7:0]               arlen_q, arlen_d;
    logic [AW-1:0]            next_addr_q, next_addr_d;
    logic [SW-1:0]            req_left_q, req_left_d;
    logic [SW-1:0]            out_left_q, out_left_d;
    logic [CW-1:0]            rsv_q, rsv_d;
    logic [FIFO_DEPTH_LG-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_LG-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]          count_q, count_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;

    logic [DATA_WIDTH-1:0]    fifo_mem [DEPTH];

    logic                     latch_c, commit_now_c, commit_vs_c, commit_c;
    logic [AW-1:0]            commit_addr_c;
    logic [SW-1:0]            commit_size_c;
    logic [SW-1:0]            len_c;
    logic [CW-1:0]            free_c;
    logic                     issue_c, rd_en_c, stream_done_c;
    logic                     unused_c;

    assign unused_c = ^{m_axi_rid, m_axi_rresp, m_axi_rlast};

    // Swap acceptance: a request is not re-latched while one is pending or just acknowledged.
    assign latch_c       = swap_fb && !pend_valid_q && !fb_swapped_q;
    assign commit_now_c  = latch_c && !swap_fb_enable_vsync;
    assign commit_vs_c   = pend_valid_q && vsync;
    assign commit_c      = commit_now_c || commit_vs_c;
    assign commit_addr_c = commit_now_c ? fb_addr : pend_addr_q;
    assign commit_size_c = commit_now_c ? fb_size : pend_size_q;

    // Burst sizing against FIFO space not already promised to in-flight beats.
    assign len_c   = (req_left_q >= SW'(BURST_LEN)) ? SW'(BURST_LEN) : req_left_q;
    assign free_c  = CW'(DEPTH) - CW'(count_q) - rsv_q;
    assign issue_c = (state_q == S_FETCH) && !arvalid_q && (req_left_q != '0) &&
                     (free_c >= CW'(len_c));

    assign rd_en_c       = (count_q != '0) && (!tvalid_q || m_pixel_axis_tready);
    assign stream_done_c = tvalid_q && m_pixel_axis_tready && tlast_q;

    // Next-state for swap, scan FSM, AR issue, credits, FIFO and output stage.
    always_comb begin
        state_d       = state_q;
        pend_valid_d  = pend_valid_q;
        pend_addr_d   = pend_addr_q;
        pend_size_d   = pend_size_q;
        front_valid_d = front_valid_q;
        front_addr_d  = front_addr_q;
        front_size_d  = front_size_q;
        fb_swapped_d  = commit_c;
        overrun_d     = vsync && (state_q != S_IDLE);
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        arlen_d       = arlen_q;
        next_addr_d   = next_addr_q;
        req_left_d    = req_left_q;
        out_left_d    = out_left_q;
        rsv_d         = rsv_q + (issue_c ? CW'(len_c) : CW'(0)) - (m_axi_rvalid ? CW'(1) : CW'(0));
        wr_ptr_d      = wr_ptr_q + (m_axi_rvalid ? FIFO_DEPTH_LG'(1) : FIFO_DEPTH_LG'(0));
        rd_ptr_d      = rd_ptr_q + (rd_en_c ? FIFO_DEPTH_LG'(1) : FIFO_DEPTH_LG'(0));
        count_d       = count_q + (m_axi_rvalid ? CNTW'(1) : CNTW'(0)) - (rd_en_c ? CNTW'(1) : CNTW'(0));
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tdata_d       = tdata_q;

        if (latch_c && swap_fb_enable_vsync) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = fb_addr;
            pend_size_d  = fb_size;
        end
        if (commit_vs_c) begin
            pend_valid_d = 1'b0;
        end
        if (commit_c) begin
            front_valid_d = 1'b1;
            front_addr_d  = commit_addr_c;
            front_size_d  = commit_size_c;
        end

        if (rd_en_c) begin
            tvalid_d   = 1'b1;
            tdata_d    = fifo_mem[rd_ptr_q];
            tlast_d    = (out_left_q == SW'(1));
            out_left_d = out_left_q - SW'(1);
        end else if (tvalid_q && m_pixel_axis_tready) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        if (arvalid_q && m_axi_arready) begin
            arvalid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (vsync && (front_valid_q || commit_c)) begin
                    state_d     = S_FETCH;
                    next_addr_d = commit_c ? commit_addr_c : front_addr_q;
                    req_left_d  = SW'((commit_c ? commit_size_c : front_size_q) >> PIX_SHIFT);
                    out_left_d  = SW'((commit_c ? commit_size_c : front_size_q) >> PIX_SHIFT);
                end
            end
            S_FETCH: begin
                if (issue_c) begin
                    arvalid_d   = 1'b1;
                    araddr_d    = next_addr_q;
                    arlen_d     = 8'(len_c - SW'(1));
                    next_addr_d = next_addr_q + (AW'(len_c) << BYTE_SHIFT);
                    req_left_d  = req_left_q - len_c;
                end else if ((req_left_q == '0) && !arvalid_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (stream_done_c) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            pend_valid_q  <= 1'b0;
            pend_addr_q   <= '0;
            pend_size_q   <= '0;
            front_valid_q <= 1'b0;
            front_addr_q  <= '0;
            front_size_q  <= '0;
            fb_swapped_q  <= 1'b0;
            overrun_q     <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            next_addr_q   <= '0;
            req_left_q    <= '0;
            out_left_q    <= '0;
            rsv_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tdata_q       <= '0;
        end else begin
            state_q       <= state_d;
            pend_valid_q  <= pend_valid_d;
            pend_addr_q   <= pend_addr_d;
            pend_size_q   <= pend_size_d;
            front_valid_q <= front_valid_d;
            front_addr_q  <= front_addr_d;
            front_size_q  <= front_size_d;
            fb_swapped_q  <= fb_swapped_d;
            overrun_q     <= overrun_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            arlen_q       <= arlen_d;
            next_addr_q   <= next_addr_d;
            req_left_q    <= req_left_d;
            out_left_q    <= out_left_d;
            rsv_q         <= rsv_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tdata_q       <= tdata_d;
        end
    end

    // Pixel FIFO storage; every R beat lands here (space is reserved before the AR goes out).
    always_ff @(posedge aclk) begin
        if (m_axi_rvalid) begin
            fifo_mem[wr_ptr_q] <= m_axi_rdata;
        end
    end

    assign fb_swapped          = fb_swapped_q;
    assign scan_overrun        = overrun_q;
    assign m_axi_arid          = '0;
    assign m_axi_araddr        = araddr_q;
    assign m_axi_arlen         = arlen_q;
    assign m_axi_arsize        = 3'(BYTE_SHIFT);
    assign m_axi_arburst       = 2'b01;
    assign m_axi_arlock        = 1'b0;
    assign m_axi_arcache       = 4'b0011;
    assign m_axi_arprot        = 3'b000;
    assign m_axi_arvalid       = arvalid_q;
    assign m_axi_rready        = 1'b1;
    assign m_pixel_axis_tvalid = tvalid_q;
    assign m_pixel_axis_tlast  = tlast_q;
    assign m_pixel_axis_tdata  = tdata_q;

endmodule

// File: tb/tb_fb_swap_scanout.sv
// tb_fb_swap_scanout: randomized AXI memory/sink model with a frame-level reference scoreboard.
module tb_fb_swap_scanout;

    localparam int unsigned AW    = 32;
    localparam int unsigned IW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned SW    = 20;
    localparam int unsigned BL    = 16;
    localparam int unsigned FDL   = 6;
    localparam int unsigned DEPTH = 1 << FDL;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          swap_fb, swap_fb_enable_vsync, vsync;
    logic [AW-1:0] fb_addr;
    logic [SW-1:0] fb_size;
    logic          fb_swapped, scan_overrun;
    logic [IW-1:0] m_axi_arid;
    logic [AW-1:0] m_axi_araddr;
    logic [7:0]    m_axi_arlen;
    logic [2:0]    m_axi_arsize;
    logic [1:0]    m_axi_arburst;
    logic          m_axi_arlock;
    logic [3:0]    m_axi_arcache;
    logic [2:0]    m_axi_arprot;
    logic          m_axi_arvalid, m_axi_arready;
    logic [IW-1:0] m_axi_rid;
    logic [DW-1:0] m_axi_rdata;
    logic [1:0]    m_axi_rresp;
    logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic          tvalid, tready, tlast;
    logic [DW-1:0] tdata;

    always #5 aclk = ~aclk;

    fb_swap_scanout dut (
        .aclk(aclk), .resetn(resetn),
        .swap_fb(swap_fb), .swap_fb_enable_vsync(swap_fb_enable_vsync),
        .fb_addr(fb_addr), .fb_size(fb_size), .fb_swapped(fb_swapped),
        .vsync(vsync), .scan_overrun(scan_overrun),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .m_pixel_axis_tvalid(tvalid), .m_pixel_axis_tready(tready),
        .m_pixel_axis_tlast(tlast), .m_pixel_axis_tdata(tdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Reference expectations and observation counters.
    logic [31:0] exp_ar_addr[$];
    logic [7:0]  exp_ar_len[$];
    logic [32:0] exp_w[$];
    logic [31:0] s_addr[$];
    int          s_left[$];
    int          ar_cnt = 0, ar_beats = 0, words_acc = 0, words_in_frame = 0, frames_done = 0;
    bit          stall = 1'b0;
    int          tready_pct = 70;

    bit          m_valid = 1'b0, m_pend = 1'b0;
    logic [31:0] m_addr, p_addr;
    logic [19:0] m_size, p_size;

    function automatic void push_frame(input logic [31:0] base, input logic [19:0] size);
        int          words;
        int          rem;
        logic [31:0] a;
        words = int'(size) / 2;
        rem   = words;
        a     = base;
        while (rem > 0) begin
            int n;
            n = (rem > int'(BL)) ? int'(BL) : rem;
            exp_ar_addr.push_back(a);
            exp_ar_len.push_back(8'(n - 1));
            a   = a + 32'(n * 4);
            rem = rem - n;
        end
        for (int i = 0; i < words; i++)
            exp_w.push_back({(i == words - 1), mem_word(base + 32'(i * 4))});
    endfunction

    // AXI slave, pixel sink and protocol monitor: observe at negedge, drive after posedge.
    initial begin : bus_model
        bit          t_hold, a_hold;
        logic [31:0] h_data, h_addr;
        logic        h_last;
        logic [7:0]  h_len;
        logic [32:0] e;
        t_hold = 0; a_hold = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rlast = 0;
        m_axi_rid = '0; m_axi_rresp = '0; tready = 0;
        forever begin
            @(negedge aclk);
            if (!resetn) begin
                t_hold = 0; a_hold = 0; words_in_frame = 0;
            end else begin
                if (a_hold) begin
                    check_eq("ar_hold_valid", m_axi_arvalid, 1);
                    check_eq("ar_hold_addr", m_axi_araddr, h_addr);
                    check_eq("ar_hold_len", m_axi_arlen, h_len);
                end
                a_hold = m_axi_arvalid && !m_axi_arready;
                h_addr = m_axi_araddr; h_len = m_axi_arlen;
                if (m_axi_arvalid && m_axi_arready) begin
                    ar_cnt++;
                    ar_beats += int'(m_axi_arlen) + 1;
                    if (exp_ar_addr.size() == 0) check_eq("ar_unexpected", 1, 0);
                    else begin
                        check_eq("ar_addr", m_axi_araddr, exp_ar_addr.pop_front());
                        check_eq("ar_len", m_axi_arlen, exp_ar_len.pop_front());
                    end
                    s_addr.push_back(m_axi_araddr);
                    s_left.push_back(int'(m_axi_arlen) + 1);
                end
                if (m_axi_rvalid && s_addr.size() != 0) begin
                    s_addr[0] = s_addr[0] + 32'd4;
                    s_left[0] = s_left[0] - 1;
                    if (s_left[0] == 0) begin
                        void'(s_addr.pop_front());
                        void'(s_left.pop_front());
                    end
                end
                if (t_hold) begin
                    check_eq("stream_hold_valid", tvalid, 1);
                    check_eq("stream_hold_data", tdata, h_data);
                    check_eq("stream_hold_last", tlast, h_last);
                end
                t_hold = tvalid && !tready;
                h_data = tdata; h_last = tlast;
                if (tvalid && tready) begin
                    words_acc++;
                    words_in_frame++;
                    if (exp_w.size() == 0) check_eq("word_unexpected", 1, 0);
                    else begin
                        e = exp_w.pop_front();
                        check_eq("tdata", tdata, e[31:0]);
                        check_eq("tlast", tlast, e[32]);
                    end
                    if (tlast) begin
                        frames_done++;
                        words_in_frame = 0;
                    end
                end
            end
            @(posedge aclk);
            #1;
            if (!resetn) begin
                s_addr.delete(); s_left.delete();
                m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; tready = 0;
            end else begin
                m_axi_arready = ($urandom_range(0, 99) < 60);
                if (s_addr.size() != 0 && $urandom_range(0, 99) < 80) begin
                    m_axi_rvalid = 1;
                    m_axi_rdata  = mem_word(s_addr[0]);
                    m_axi_rlast  = (s_left[0] == 1);
                    m_axi_rresp  = 2'($urandom_range(0, 3));
                end else begin
                    m_axi_rvalid = 0;
                    m_axi_rlast  = 0;
                end
                tready = !stall && ($urandom_range(0, 99) < tready_pct);
            end
        end
    end

    task automatic do_swap(input logic [31:0] a, input logic [19:0] s, input bit en);
        @(posedge aclk); #1;
        swap_fb = 1; fb_addr = a; fb_size = s; swap_fb_enable_vsync = en;
        @(negedge aclk); check_eq("swap_latch_cycle", fb_swapped, 0);
        if (!en) begin
            @(negedge aclk); check_eq("swap_pulse", fb_swapped, 1);
            @(posedge aclk); #1; swap_fb = 0;
            @(negedge aclk); check_eq("swap_single_pulse", fb_swapped, 0);
            m_addr = a; m_size = s; m_valid = 1;
        end else begin
            repeat (5) begin
                @(negedge aclk); check_eq("swap_wait_vsync", fb_swapped, 0);
            end
            p_addr = a; p_size = s; m_pend = 1;
        end
    endtask

    task automatic pulse_vsync(input bit idle);
        @(posedge aclk); #1;
        vsync = 1;
        if (m_pend) begin
            m_addr = p_addr; m_size = p_size; m_valid = 1;
        end
        if (idle && m_valid) push_frame(m_addr, m_size);
        @(negedge aclk); check_eq("vsync_cycle_no_pulse", fb_swapped, 0);
        @(posedge aclk); #1; vsync = 0;
        if (m_pend) begin
            @(negedge aclk); check_eq("swap_pulse_after_vsync", fb_swapped, 1);
            swap_fb = 0; m_pend = 0;
            @(negedge aclk); check_eq("swap_single_pulse_vs", fb_swapped, 0);
        end
    endtask

    task automatic wait_frame();
        int target;
        int cyc;
        target = frames_done + 1;
        cyc    = 0;
        while (frames_done < target && cyc < 6000) begin
            @(negedge aclk); cyc++;
        end
        check_eq("frame_done", frames_done >= target, 1);
        check_eq("ar_queue_drained", exp_ar_addr.size(), 0);
        check_eq("word_queue_drained", exp_w.size(), 0);
    endtask

    task automatic wait_words(input int n);
        int cyc;
        cyc = 0;
        while (words_in_frame < n && cyc < 3000) begin
            @(negedge aclk); cyc++;
        end
        check_eq("reach_word_count", words_in_frame >= n, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_fb_swapped"}, fb_swapped, 0);
        check_eq({tag, "_overrun"}, scan_overrun, 0);
        check_eq({tag, "_arvalid"}, m_axi_arvalid, 0);
        check_eq({tag, "_tvalid"}, tvalid, 0);
        check_eq({tag, "_tlast"}, tlast, 0);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int a0, b0, w0;
        resetn = 0; swap_fb = 0; swap_fb_enable_vsync = 0; vsync = 0;
        fb_addr = '0; fb_size = '0;
        repeat (2) @(negedge aclk);
        check_idle_outputs("reset");
        check_eq("arsize", m_axi_arsize, 3'd2);
        check_eq("arburst", m_axi_arburst, 2'b01);
        check_eq("arcache", m_axi_arcache, 4'b0011);
        check_eq("rready", m_axi_rready, 1);
        @(posedge aclk); #1; resetn = 1;

        // vsync with no front buffer must not start a frame
        a0 = ar_cnt;
        pulse_vsync(1);
        repeat (30) @(negedge aclk);
        check_eq("no_front_no_ar", ar_cnt, a0);
        check_eq("no_front_no_tvalid", tvalid, 0);

        // immediate swap, 32-word frame in two full bursts
        do_swap(32'h0000_1000, 20'd64, 0);
        a0 = ar_cnt;
        pulse_vsync(1);
        wait_frame();
        check_eq("frame64_ar_count", ar_cnt - a0, 2);

        // vsync-synchronised swap: the committing vsync uses the new address
        do_swap(32'h0000_8000, 20'd64, 1);
        pulse_vsync(1);
        wait_frame();

        // partial last burst: len 15 then len 3, tlast on word 20
        do_swap(32'h0000_2000, 20'd40, 0);
        a0 = ar_cnt;
        pulse_vsync(1);
        wait_frame();
        check_eq("frame40_ar_count", ar_cnt - a0, 2);

        // long sink stall: AR issue must stop once FIFO space is all reserved
        do_swap(32'h0000_4000, 20'd512, 0);
        b0 = ar_beats; w0 = words_acc;
        pulse_vsync(1);
        wait_words(10);
        stall = 1;
        repeat (100) @(negedge aclk);
        a0 = ar_cnt;
        repeat (100) @(negedge aclk);
        check_eq("stall_no_new_ar", ar_cnt, a0);
        check_eq("stall_credit_bound", (ar_beats - b0) - (words_acc - w0) <= int'(DEPTH) + 1, 1);
        stall = 0;
        wait_frame();

        // vsync mid-frame: overrun pulse, frame completes without restart
        do_swap(32'h0000_1000, 20'd64, 0);
        pulse_vsync(1);
        wait_words(10);
        @(posedge aclk); #1; vsync = 1;
        @(negedge aclk); check_eq("overrun_vsync_cycle", scan_overrun, 0);
        @(posedge aclk); #1; vsync = 0;
        @(negedge aclk); check_eq("overrun_pulse", scan_overrun, 1);
        @(negedge aclk); check_eq("overrun_single", scan_overrun, 0);
        wait_frame();
        a0 = ar_cnt;
        repeat (40) @(negedge aclk);
        check_eq("no_restart_after_overrun", ar_cnt, a0);

        // swap latch and vsync in the same cycle: that frame already uses the new buffer
        @(posedge aclk); #1;
        swap_fb = 1; swap_fb_enable_vsync = 0; fb_addr = 32'h0000_3000; fb_size = 20'd32; vsync = 1;
        m_addr = 32'h0000_3000; m_size = 20'd32; m_valid = 1;
        push_frame(m_addr, m_size);
        @(negedge aclk); check_eq("simul_latch_cycle", fb_swapped, 0);
        @(posedge aclk); #1; vsync = 0;
        @(negedge aclk); check_eq("simul_pulse", fb_swapped, 1);
        swap_fb = 0;
        wait_frame();

        // reset during FETCH with arvalid high
        do_swap(32'h0001_0000, 20'd512, 0);
        stall = 1;
        pulse_vsync(1);
        begin
            int cyc;
            cyc = 0;
            while (!m_axi_arvalid && cyc < 100) begin
                @(negedge aclk); cyc++;
            end
            check_eq("arvalid_before_reset", m_axi_arvalid, 1);
        end
        #1; resetn = 0;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_w.delete();
        m_valid = 0; m_pend = 0; stall = 0;
        @(negedge aclk);
        check_idle_outputs("midreset");
        repeat (3) @(posedge aclk);
        #1; resetn = 1;
        a0 = ar_cnt;
        pulse_vsync(1);
        repeat (30) @(negedge aclk);
        check_eq("post_reset_front_invalid", ar_cnt, a0);
        do_swap(32'h0000_5000, 20'd64, 0);
        pulse_vsync(1);
        wait_frame();

        // randomized frames
        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra;
            logic [19:0] rs;
            bit          ren;
            ra  = $urandom & 32'hFFFF_FFC0;
            rs  = 20'(2 * $urandom_range(1, 200));
            ren = 1'($urandom_range(0, 1));
            tready_pct = $urandom_range(30, 100);
            do_swap(ra, rs, ren);
            pulse_vsync(1);
            wait_frame();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
